// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the MIPS fetch PC sequencer.
// FETCH_DELAY_SLOT_EN selects delay-slot retirement instead of squash-on-redirect.
package mips_fetch_pkg;

  localparam logic [29:0] PC_INIT_W = 30'h0000_0C00;  // 32'h0000_3000 >> 2
  localparam logic [29:0] EXC_VEC_W = 30'h0000_1060;  // 32'h0000_4180 >> 2

  typedef enum logic {
    IDLE,
    WAIT
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE,
    BR,
    JR,
    EXC
  } redirect_src_t;

  // Whether a redirect from this source kills the fetch outstanding in the same cycle.
  function automatic logic squashes(input redirect_src_t src);
`ifdef FETCH_DELAY_SLOT_EN
    return src == EXC;
`else
    return src != NONE;
`endif
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: request/address out, ack back in the same cycle as data.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/fetch_sequencer_redirect_pick.sv
// Priority selection among the redirect sources: exception > jr > branch.
module redirect_pick
  import mips_fetch_pkg::*;
#(
  parameter logic [29:0] EXC_TARGET = EXC_VEC_W
) (
  input  logic          br_valid,
  input  logic [29:0]   br_target,
  input  logic          jr_valid,
  input  logic [29:0]   jr_target,
  input  logic          exc_valid,
  output logic          rd_valid,
  output redirect_src_t rd_src,
  output logic [29:0]   rd_target
);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    rd_src    = NONE;
    rd_target = '0;
    if (exc_valid) begin
      rd_src    = EXC;
      rd_target = EXC_TARGET;
    end else if (jr_valid) begin
      rd_src    = JR;
      rd_target = jr_target;
    end else if (br_valid) begin
      rd_src    = BR;
      rd_target = br_target;
    end
  end

  assign rd_valid = (rd_src != NONE);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: launches one imem request at a time, retires acked fetches to decode.
// Optional build macro FETCH_DELAY_SLOT_EN enables MIPS branch delay-slot behaviour.
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] PC_INIT = {PC_INIT_W, 2'b00},
  parameter logic [31:0] EXC_VEC = {EXC_VEC_W, 2'b00}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      br_valid,
  input  logic [29:0]               br_target,
  input  logic                      jr_valid,
  input  logic [29:0]               jr_target,
  input  logic                      exc_valid,
  fetch_sequencer_if.master         imem,
  output logic                      pc_valid,
  output logic [29:0]               pc_out
);

  localparam logic [29:0] PC_W  = PC_INIT[31:2];
  localparam logic [29:0] EXC_W = EXC_VEC[31:2];

  fetch_state_t  state_q, state_d;
  logic [29:0]   addr_q, addr_d;
  logic [29:0]   next_pc_q, next_pc_d;
  logic [29:0]   pend_tgt_q, pend_tgt_d;
  logic          pend_q, pend_d;
  logic          squash_q, squash_d;
  logic          pc_valid_d;
  logic [29:0]   pc_out_d;
  logic          rd_valid;
  redirect_src_t rd_src;
  logic [29:0]   rd_target;
  logic          acked, kill_now, launch;
  logic [29:0]   seq_pc;
`ifdef FETCH_DELAY_SLOT_EN
  logic          slot_owed_q, slot_owed_d;
`endif

  redirect_pick #(.EXC_TARGET(EXC_W)) u_pick (
    .br_valid  (br_valid),
    .br_target (br_target),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .exc_valid (exc_valid),
    .rd_valid  (rd_valid),
    .rd_src    (rd_src),
    .rd_target (rd_target)
  );

  assign acked          = (state_q == WAIT) && imem.imem_ack;
  assign kill_now       = (state_q == WAIT) && squashes(rd_src);
  assign imem.imem_req  = (state_q == WAIT);
  assign imem.imem_addr = addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    next_pc_d  = next_pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    squash_d   = squash_q;
    pc_valid_d = 1'b0;
    pc_out_d   = pc_out;
    launch     = 1'b0;
    seq_pc     = next_pc_q;
`ifdef FETCH_DELAY_SLOT_EN
    slot_owed_d = slot_owed_q;
`endif

    // Latest redirect always replaces whatever target is still pending.
    if (rd_valid) begin
      pend_d     = 1'b1;
      pend_tgt_d = rd_target;
`ifdef FETCH_DELAY_SLOT_EN
      // With nothing in flight a branch owes one sequential fetch as its delay slot.
      slot_owed_d = (rd_src != EXC) && (state_q == IDLE);
`endif
    end
    if (kill_now && !acked) squash_d = 1'b1;

    case (state_q)
      IDLE: launch = !stall;
      WAIT: begin
        if (acked) begin
          if (!(squash_q || kill_now)) begin
            pc_valid_d = 1'b1;
            pc_out_d   = addr_q;
          end
          squash_d  = 1'b0;
          seq_pc    = addr_q + 30'd1;
          next_pc_d = seq_pc;
          launch    = !stall;
          if (stall) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d = WAIT;
`ifdef FETCH_DELAY_SLOT_EN
      if (slot_owed_d) begin
        addr_d      = seq_pc;
        slot_owed_d = 1'b0;
      end else
`endif
      if (pend_d) begin
        addr_d = pend_tgt_d;
        pend_d = 1'b0;
      end else begin
        addr_d = seq_pc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= PC_W;
      next_pc_q  <= PC_W;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      squash_q   <= 1'b0;
      pc_valid   <= 1'b0;
      pc_out     <= PC_W;
`ifdef FETCH_DELAY_SLOT_EN
      slot_owed_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      next_pc_q  <= next_pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      squash_q   <= squash_d;
      pc_valid   <= pc_valid_d;
      pc_out     <= pc_out_d;
`ifdef FETCH_DELAY_SLOT_EN
      slot_owed_q <= slot_owed_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table plus randomized run against a transaction model.
module tb_fetch_sequencer;
  import mips_fetch_pkg::*;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic [29:0] PC0 = 30'h0C00;
  localparam logic [29:0] EXV = 30'h1060;

  typedef struct {
    bit          rst, stall, ack, br, jr, exc;
    logic [29:0] brt, jrt;
    bit          ereq, epv;
    logic [29:0] eaddr, epc;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    bit          doomed;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset, stall, br_valid, jr_valid, exc_valid, pc_valid;
  logic [29:0] br_target, jr_target, pc_out;
  int          n_checks = 0;
  int          n_errors = 0;

  fetch_sequencer_if imem ();

  fetch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .exc_valid (exc_valid),
    .imem      (imem),
    .pc_valid  (pc_valid),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit stl, bit ack, bit br, logic [29:0] brt, bit jr,
                              logic [29:0] jrt, bit exc, bit ereq, logic [29:0] eaddr,
                              bit epv, logic [29:0] epc);
    vec_t v;
    v.rst = rst; v.stall = stl; v.ack = ack; v.br = br; v.brt = brt; v.jr = jr; v.jrt = jrt;
    v.exc = exc; v.ereq = ereq; v.eaddr = eaddr; v.epv = epv; v.epc = epc;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    reset = v.rst; stall = v.stall; imem.imem_ack = v.ack;
    br_valid = v.br; br_target = v.brt; jr_valid = v.jr; jr_target = v.jrt; exc_valid = v.exc;
    @(posedge clk);
    #1;
    check({tag, " imem_req"}, 32'(imem.imem_req), 32'(v.ereq));
    if (v.ereq) check({tag, " imem_addr"}, 32'(imem.imem_addr), 32'(v.eaddr));
    check({tag, " pc_valid"}, 32'(pc_valid), 32'(v.epv));
    if (v.epv) check({tag, " pc_out"}, 32'(pc_out), 32'(v.epc));
  endtask

  // Transaction-level reference: at most one fetch in flight, at most one pending target.
  fetch_t      m_out[$];
  logic [29:0] m_pend[$];
  logic [29:0] m_seq;
  bit          m_owed;

  task automatic model_step(inout vec_t v);
    bit busy, win, win_exc;
    logic [29:0] tgt, a;
    fetch_t f;
    v.epv = 0; v.epc = '0;
    if (v.rst) begin
      m_out.delete(); m_pend.delete(); m_seq = PC0; m_owed = 0;
      v.ereq = 0; v.eaddr = '0;
      return;
    end
    busy    = m_out.size() != 0;
    win     = v.exc || v.jr || v.br;
    win_exc = v.exc;
    tgt     = v.exc ? EXV : (v.jr ? v.jrt : v.brt);
    if (win) begin
      if (busy && (!DS || win_exc)) m_out[0].doomed = 1;
      m_pend.delete();
      m_pend.push_back(tgt);
      if (DS) m_owed = !win_exc && !busy;
    end
    if (busy && v.ack) begin
      f = m_out.pop_front();
      if (!f.doomed) begin v.epv = 1; v.epc = f.addr; end
      m_seq = f.addr + 30'd1;
    end
    if (m_out.size() == 0 && !v.stall) begin
      if (m_owed) begin a = m_seq; m_owed = 0; end
      else if (m_pend.size() != 0) a = m_pend.pop_front();
      else a = m_seq;
      m_out.push_back('{addr: a, doomed: 1'b0});
    end
    v.ereq  = m_out.size() != 0;
    v.eaddr = v.ereq ? m_out[0].addr : '0;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    reset = 1; stall = 0; br_valid = 0; jr_valid = 0; exc_valid = 0;
    br_target = '0; jr_target = '0; imem.imem_ack = 0;
    repeat (2) @(posedge clk);
    #1;

    //            rst stl ack br brt       jr jrt           exc  req addr                  pv  pc
    tbl.push_back(mk(1, 0, 0, 0, 0,        0, 0,            0,   0, 0,                    0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC00,              0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC01,              1,  30'hC00));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0,   1, 30'hC01,              0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0,   1, 30'hC01,              0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0,   1, 30'hC01,              0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC02,              1,  30'hC01));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC03,              1,  30'hC02));
    tbl.push_back(mk(0, 0, 1, 1, 30'hD00,  0, 0,            1,   1, EXV,                  0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'h1061,             1,  EXV));
    tbl.push_back(mk(0, 0, 1, 1, 30'hD00,  1, 30'hE80,      0,   1, 30'hE80,              DS, 30'h1061));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0,   1, 30'hE80,              0,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0,        0, 0,            0,   0, 0,                    1,  30'hE80));
    tbl.push_back(mk(0, 1, 1, 0, 0,        0, 0,            0,   0, 0,                    0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,        1, 30'hE00,      0,   0, 0,                    0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,        0, 0,            0,   0, 0,                    0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0,   1, DS ? 30'hE81 : 30'hE00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, DS ? 30'hE00 : 30'hE01, 1, DS ? 30'hE81 : 30'hE00));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, DS ? 30'hE01 : 30'hE02, 1, DS ? 30'hE00 : 30'hE01));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0,            0,   1, DS ? 30'hE01 : 30'hE02, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,        0, 0,            0,   0, 0,                    0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC00,              0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC01,              1,  30'hC00));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC02,              1,  30'hC01));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hC03,              1,  30'hC02));
    tbl.push_back(mk(0, 0, 0, 1, 30'hD00,  0, 0,            0,   1, 30'hC03,              0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hD00,              DS, 30'hC03));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hD01,              1,  30'hD00));
    tbl.push_back(mk(0, 0, 0, 1, 30'hD40,  0, 0,            0,   1, 30'hD01,              0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 30'hD80,      0,   1, 30'hD01,              0,  0));
    tbl.push_back(mk(0, 0, 0, 1, 30'hDC0,  0, 0,            0,   1, 30'hD01,              0,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'hDC0,              DS, 30'hD01));
    tbl.push_back(mk(0, 0, 1, 0, 0,        1, 30'h3FFF_FFFF, 0,  1, 30'h3FFF_FFFF,        DS, 30'hDC0));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'h0,                1,  30'h3FFF_FFFF));
    tbl.push_back(mk(0, 0, 1, 0, 0,        0, 0,            0,   1, 30'h1,                1,  30'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].rst) begin
        check($sformatf("vec%0d reset pc_out", i), 32'(pc_out), 32'(PC0));
        check($sformatf("vec%0d reset imem_addr", i), 32'(imem.imem_addr), 32'(PC0));
      end
    end

    for (int i = 0; i < 3000; i++) begin
      v.rst   = (i == 0) || ($urandom_range(149) == 0);
      v.stall = ($urandom_range(3) == 0);
      v.ack   = $urandom_range(1) == 1;
      v.br    = ($urandom_range(7) == 0);
      v.jr    = ($urandom_range(9) == 0);
      v.exc   = ($urandom_range(24) == 0);
      v.brt   = 30'($urandom);
      v.jrt   = ($urandom_range(7) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      model_step(v);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
